// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
//   Shared definitions for the data-memory arbiter:
//     - FSM state encoding (IDLE / ACCESS / RESP)
//     - requester port identifiers (CPU / debug-loader)
//     - other_port(): the requester that is not the given one
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  function automatic logic other_port(input logic port);
    return ~port;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
//   Two-requester picker. Bit PORT_CPU / PORT_DBG of req_i is the request of
//   that port. A lone requester always wins. On a tie the CPU wins when
//   FIXED_PRIO != 0, otherwise the port that was not granted last wins.
//
//   Ports:
//     req_i    [1:0]  request vector, indexed by port id
//     last_i          port id of the most recent grant
//     valid_o         at least one request is present
//     winner_o        port id of the winning requester (PORT_CPU when idle)
// -----------------------------------------------------------------------------
module rr_arbiter2
  import arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       valid_o,
  output logic       winner_o
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned (which would infer a latch).
    valid_o  = |req_i;
    winner_o = PORT_CPU;
    if (req_i[PORT_CPU] && req_i[PORT_DBG]) begin
      winner_o = (FIXED_PRIO != 0) ? PORT_CPU : other_port(last_i);
    end else if (req_i[PORT_DBG]) begin
      winner_o = PORT_DBG;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//   Shares a single-port, one-cycle-read-latency data memory between the CPU
//   load/store path and a debug/loader port. One access at a time:
//     IDLE   -> pick a winner, capture its addr/we/wdata
//     ACCESS -> drive the memory from the captured values, pulse x_gnt
//     RESP   -> (reads only) return memory data, pulse x_rvalid
//   A write completes at gnt, a read at rvalid. The CPU is stalled while its
//   request is pending and not completing in the current cycle.
//
//   Ports:
//     I_clk, I_rst                  clock, async active-low reset
//     I_cpu_req/we/addr/wdata       CPU request (held until completion)
//     O_cpu_gnt/rvalid/rdata/stall  CPU response and stall
//     I_dbg_req/we/addr/wdata       debug/loader request
//     O_dbg_gnt/rvalid/rdata        debug/loader response
//     O_mem_memrw/address/data      memory write enable, address, write data
//     I_mem_data                    memory read data (valid cycle after addr)
// -----------------------------------------------------------------------------
module data_mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_cpu_req,
  input  logic              I_cpu_we,
  input  logic [ADDR_W-1:0] I_cpu_addr,
  input  logic [DATA_W-1:0] I_cpu_wdata,
  output logic              O_cpu_gnt,
  output logic              O_cpu_rvalid,
  output logic [DATA_W-1:0] O_cpu_rdata,
  output logic              O_cpu_stall,
  input  logic              I_dbg_req,
  input  logic              I_dbg_we,
  input  logic [ADDR_W-1:0] I_dbg_addr,
  input  logic [DATA_W-1:0] I_dbg_wdata,
  output logic              O_dbg_gnt,
  output logic              O_dbg_rvalid,
  output logic [DATA_W-1:0] O_dbg_rdata,
  output logic              O_mem_memrw,
  output logic [ADDR_W-1:0] O_mem_address,
  output logic [DATA_W-1:0] O_mem_data,
  input  logic [DATA_W-1:0] I_mem_data
);

  logic [1:0]        state_q,     state_d;
  logic              owner_q,     owner_d;
  logic              last_q,      last_d;
  logic              we_q,        we_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic arb_valid;
  logic arb_winner;

  rr_arbiter2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .req_i    ({I_dbg_req, I_cpu_req}),
    .last_i   (last_q),
    .valid_o  (arb_valid),
    .winner_o (arb_winner)
  );

  logic in_access;
  logic in_resp;
  logic cpu_owns;
  logic dbg_owns;
  logic cpu_done;

  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);
  assign cpu_owns  = (owner_q == PORT_CPU);
  assign dbg_owns  = (owner_q == PORT_DBG);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = ACCESS;
          owner_d = arb_winner;
          // The grant always follows in the very next cycle, so recording the
          // winner here is equivalent to recording it at the grant.
          last_d  = arb_winner;
          if (arb_winner == PORT_DBG) begin
            we_d    = I_dbg_we;
            addr_d  = I_dbg_addr;
            wdata_d = I_dbg_wdata;
          end else begin
            we_d    = I_cpu_we;
            addr_d  = I_cpu_addr;
            wdata_d = I_cpu_wdata;
          end
        end
      end
      ACCESS: begin
        state_d = we_q ? IDLE : RESP;
      end
      RESP: begin
        state_d = IDLE;
        if (cpu_owns) cpu_rdata_d = I_mem_data;
        else          dbg_rdata_d = I_mem_data;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      state_q     <= IDLE;
      owner_q     <= PORT_CPU;
      last_q      <= PORT_DBG;   // so the CPU wins the first tie
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // updates from the pre-edge values, independent of statement order.
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Memory drive: write enable is qualified by ACCESS so it falls as soon as
  // the state register is asynchronously reset.
  assign O_mem_memrw   = in_access & we_q;
  assign O_mem_address = addr_q;
  assign O_mem_data    = wdata_q;

  assign O_cpu_gnt    = in_access & cpu_owns;
  assign O_dbg_gnt    = in_access & dbg_owns;
  assign O_cpu_rvalid = in_resp & cpu_owns;
  assign O_dbg_rvalid = in_resp & dbg_owns;

  // Load data is passed straight through in RESP and held afterwards.
  assign O_cpu_rdata = O_cpu_rvalid ? I_mem_data : cpu_rdata_q;
  assign O_dbg_rdata = O_dbg_rvalid ? I_mem_data : dbg_rdata_q;

  assign cpu_done    = (O_cpu_gnt & we_q) | O_cpu_rvalid;
  assign O_cpu_stall = I_cpu_req & ~cpu_done;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//   Two arbiter instances share one set of request inputs: u_rr (round-robin)
//   and u_fp (CPU priority). Each has its own behavioural synchronous memory.
//   Directed scenarios plus a randomized two-port run checked against a
//   transaction-level model of the arbitration and memory contents.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_clr;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;

  logic        rr_cpu_gnt, rr_cpu_rvalid, rr_cpu_stall, rr_dbg_gnt, rr_dbg_rvalid, rr_mem_we;
  logic [31:0] rr_cpu_rdata, rr_dbg_rdata, rr_mem_addr, rr_mem_wdata, rr_mem_rdata;
  logic        fp_cpu_gnt, fp_cpu_rvalid, fp_cpu_stall, fp_dbg_gnt, fp_dbg_rvalid, fp_mem_we;
  logic [31:0] fp_cpu_rdata, fp_dbg_rdata, fp_mem_addr, fp_mem_wdata, fp_mem_rdata;

  int vectors    = 0;
  int miscompares = 0;
  bit rand_done;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) u_rr (
    .I_clk(clk), .I_rst(rst_n),
    .I_cpu_req(cpu_req), .I_cpu_we(cpu_we), .I_cpu_addr(cpu_addr), .I_cpu_wdata(cpu_wdata),
    .O_cpu_gnt(rr_cpu_gnt), .O_cpu_rvalid(rr_cpu_rvalid), .O_cpu_rdata(rr_cpu_rdata),
    .O_cpu_stall(rr_cpu_stall),
    .I_dbg_req(dbg_req), .I_dbg_we(dbg_we), .I_dbg_addr(dbg_addr), .I_dbg_wdata(dbg_wdata),
    .O_dbg_gnt(rr_dbg_gnt), .O_dbg_rvalid(rr_dbg_rvalid), .O_dbg_rdata(rr_dbg_rdata),
    .O_mem_memrw(rr_mem_we), .O_mem_address(rr_mem_addr), .O_mem_data(rr_mem_wdata),
    .I_mem_data(rr_mem_rdata)
  );

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) u_fp (
    .I_clk(clk), .I_rst(rst_n),
    .I_cpu_req(cpu_req), .I_cpu_we(cpu_we), .I_cpu_addr(cpu_addr), .I_cpu_wdata(cpu_wdata),
    .O_cpu_gnt(fp_cpu_gnt), .O_cpu_rvalid(fp_cpu_rvalid), .O_cpu_rdata(fp_cpu_rdata),
    .O_cpu_stall(fp_cpu_stall),
    .I_dbg_req(dbg_req), .I_dbg_we(dbg_we), .I_dbg_addr(dbg_addr), .I_dbg_wdata(dbg_wdata),
    .O_dbg_gnt(fp_dbg_gnt), .O_dbg_rvalid(fp_dbg_rvalid), .O_dbg_rdata(fp_dbg_rdata),
    .O_mem_memrw(fp_mem_we), .O_mem_address(fp_mem_addr), .O_mem_data(fp_mem_wdata),
    .I_mem_data(fp_mem_rdata)
  );

  // Environment memories: 64 words, synchronous read, write-enable gated.
  logic [31:0] mem_rr [64];
  logic [31:0] mem_fp [64];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem_rr[i] <= '0;
    end else if (rr_mem_we) begin
      mem_rr[rr_mem_addr[7:2]] <= rr_mem_wdata;
    end
    rr_mem_rdata <= mem_rr[rr_mem_addr[7:2]];
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem_fp[i] <= '0;
    end else if (fp_mem_we) begin
      mem_fp[fp_mem_addr[7:2]] <= fp_mem_wdata;
    end
    fp_mem_rdata <= mem_fp[fp_mem_addr[7:2]];
  end

  task automatic do_reset(input bit clr);
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    @(negedge clk);
    rst_n   = 1'b0;
    mem_clr = clr;
    repeat (2) @(negedge clk);
    mem_clr = 1'b0;
    rst_n   = 1'b1;
  endtask

  // Both ports request while reset is held; CPU must be granted first.
  task automatic test_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h1111;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h44; dbg_wdata = 32'h2222;
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({rr_mem_we, fp_mem_we, rr_cpu_gnt, rr_dbg_gnt, rr_cpu_rvalid, rr_dbg_rvalid} !== 6'b0) begin
        miscompares++;
        $display("FAIL reset_ctrl: got %b want 000000",
                 {rr_mem_we, fp_mem_we, rr_cpu_gnt, rr_dbg_gnt, rr_cpu_rvalid, rr_dbg_rvalid});
      end
      vectors++;
      if (rr_mem_addr !== 32'h0 || rr_cpu_rdata !== 32'h0 || rr_dbg_rdata !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_regs: addr=%h cpu_rdata=%h dbg_rdata=%h want all 0",
                 rr_mem_addr, rr_cpu_rdata, rr_dbg_rdata);
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (rr_cpu_gnt !== 1'b0 || rr_mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_idle: gnt=%b memrw=%b want 0 0", rr_cpu_gnt, rr_mem_we);
    end
    @(negedge clk); #1;
    vectors++;
    if ({rr_cpu_gnt, rr_dbg_gnt, fp_cpu_gnt, fp_dbg_gnt} !== 4'b1010) begin
      miscompares++;
      $display("FAIL reset_first_winner: got %b want 1010",
               {rr_cpu_gnt, rr_dbg_gnt, fp_cpu_gnt, fp_dbg_gnt});
    end
    @(negedge clk);
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // CPU store then load of the same word.
  task automatic test_store_load();
    do_reset(1'b1);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    #1;
    vectors++;
    if (rr_cpu_stall !== 1'b1 || rr_cpu_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL store_n: stall=%b gnt=%b want 1 0", rr_cpu_stall, rr_cpu_gnt);
    end
    @(negedge clk); #1;
    vectors++;
    if (rr_cpu_gnt !== 1'b1 || rr_mem_we !== 1'b1 || rr_cpu_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL store_n1: gnt=%b memrw=%b stall=%b want 1 1 0", rr_cpu_gnt, rr_mem_we, rr_cpu_stall);
    end
    vectors++;
    if (rr_mem_addr !== 32'h10 || rr_mem_wdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL store_bus: addr=%h data=%h want 00000010 deadbeef", rr_mem_addr, rr_mem_wdata);
    end
    @(negedge clk);
    cpu_we = 1'b0;
    #1;
    vectors++;
    if (rr_cpu_stall !== 1'b1 || rr_cpu_gnt !== 1'b0 || rr_mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL load_n: stall=%b gnt=%b memrw=%b want 1 0 0", rr_cpu_stall, rr_cpu_gnt, rr_mem_we);
    end
    @(negedge clk); #1;
    vectors++;
    if (rr_cpu_gnt !== 1'b1 || rr_mem_we !== 1'b0 || rr_cpu_stall !== 1'b1 || rr_mem_addr !== 32'h10) begin
      miscompares++;
      $display("FAIL load_n1: gnt=%b memrw=%b stall=%b addr=%h want 1 0 1 00000010",
               rr_cpu_gnt, rr_mem_we, rr_cpu_stall, rr_mem_addr);
    end
    @(negedge clk); #1;
    vectors++;
    if (rr_cpu_rvalid !== 1'b1 || rr_cpu_rdata !== 32'hDEADBEEF || rr_cpu_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL load_n2: rvalid=%b rdata=%h stall=%b want 1 deadbeef 0",
               rr_cpu_rvalid, rr_cpu_rdata, rr_cpu_stall);
    end
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    vectors++;
    if (rr_cpu_rvalid !== 1'b0 || rr_cpu_rdata !== 32'hDEADBEEF || rr_cpu_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL load_hold: rvalid=%b rdata=%h stall=%b want 0 deadbeef 0",
               rr_cpu_rvalid, rr_cpu_rdata, rr_cpu_stall);
    end
  endtask

  // Debug loader writes 1..4 to 0x0..0xC; CPU idle.
  task automatic test_dbg_loader();
    do_reset(1'b1);
    for (int t = 0; t < 9; t++) begin
      if (t == 8) begin
        dbg_req = 1'b0;
      end else if (t % 2 == 0) begin
        dbg_req = 1'b1; dbg_we = 1'b1;
        dbg_addr  = 32'(t / 2) * 32'd4;
        dbg_wdata = 32'(t / 2 + 1);
      end
      #1;
      vectors++;
      if (rr_dbg_gnt !== (t % 2 == 1) || rr_mem_we !== (t % 2 == 1) || rr_cpu_stall !== 1'b0) begin
        miscompares++;
        $display("FAIL loader_t%0d: gnt=%b memrw=%b stall=%b want %b %b 0",
                 t, rr_dbg_gnt, rr_mem_we, rr_cpu_stall, t % 2 == 1, t % 2 == 1);
      end
      if (t % 2 == 1) begin
        vectors++;
        if (rr_mem_addr !== 32'((t - 1) / 2) * 32'd4 || rr_mem_wdata !== 32'((t - 1) / 2 + 1)) begin
          miscompares++;
          $display("FAIL loader_bus_t%0d: addr=%h data=%h want %h %h", t, rr_mem_addr, rr_mem_wdata,
                   32'((t - 1) / 2) * 32'd4, 32'((t - 1) / 2 + 1));
        end
      end
      @(negedge clk);
    end
  endtask

  // Both ports read continuously, round-robin: CPU, dbg, CPU, dbg.
  task automatic test_alternate();
    do_reset(1'b0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h8;
    for (int t = 0; t < 12; t++) begin
      int  ph   = t % 3;
      bit  port = ((t / 3) % 2) == 1;
      logic [3:0] exp_ctl = {ph == 1 && !port, ph == 1 && port, ph == 2 && !port, ph == 2 && port};
      #1;
      vectors++;
      if ({rr_cpu_gnt, rr_dbg_gnt, rr_cpu_rvalid, rr_dbg_rvalid} !== exp_ctl ||
          rr_cpu_stall !== !(ph == 2 && !port)) begin
        miscompares++;
        $display("FAIL rr_alt_t%0d: gnt/rvalid=%b stall=%b want %b %b", t,
                 {rr_cpu_gnt, rr_dbg_gnt, rr_cpu_rvalid, rr_dbg_rvalid}, rr_cpu_stall,
                 exp_ctl, !(ph == 2 && !port));
      end
      if (ph == 2) begin
        vectors++;
        if ((!port && rr_cpu_rdata !== 32'd2) || (port && rr_dbg_rdata !== 32'd3)) begin
          miscompares++;
          $display("FAIL rr_alt_data_t%0d: cpu=%h dbg=%h want %s", t, rr_cpu_rdata, rr_dbg_rdata,
                   port ? "dbg=3" : "cpu=2");
        end
      end
      @(negedge clk);
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
  endtask

  // CPU priority: CPU wins every tie; dbg granted once CPU drops.
  task automatic test_fixed_prio();
    do_reset(1'b0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hC;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h0;
    for (int t = 0; t < 13; t++) begin
      bit cpu_on = (t < 9);
      logic [3:0] exp_ctl = {cpu_on && t % 3 == 1, t == 10, cpu_on && t % 3 == 2, t == 11};
      if (t == 9)  cpu_req = 1'b0;
      if (t == 12) dbg_req = 1'b0;
      #1;
      vectors++;
      if ({fp_cpu_gnt, fp_dbg_gnt, fp_cpu_rvalid, fp_dbg_rvalid} !== exp_ctl ||
          fp_cpu_stall !== (cpu_on && t % 3 != 2)) begin
        miscompares++;
        $display("FAIL fp_t%0d: gnt/rvalid=%b stall=%b want %b %b", t,
                 {fp_cpu_gnt, fp_dbg_gnt, fp_cpu_rvalid, fp_dbg_rvalid}, fp_cpu_stall,
                 exp_ctl, cpu_on && t % 3 != 2);
      end
      if ((exp_ctl[1] && fp_cpu_rdata !== 32'd4) || (exp_ctl[0] && fp_dbg_rdata !== 32'd1)) begin
        miscompares++;
        $display("FAIL fp_data_t%0d: cpu=%h dbg=%h want cpu=4 dbg=1", t, fp_cpu_rdata, fp_dbg_rdata);
      end
      if (exp_ctl[1] || exp_ctl[0]) vectors++;
      @(negedge clk);
    end
  endtask

  // Reset mid-write: memrw drops at once, nothing written, no later grants.
  task automatic test_reset_abort();
    do_reset(1'b1);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'h12345678;
    @(negedge clk); #1;
    vectors++;
    if (rr_mem_we !== 1'b1 || rr_cpu_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pre: memrw=%b gnt=%b want 1 1", rr_mem_we, rr_cpu_gnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (rr_mem_we !== 1'b0 || rr_cpu_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_async: memrw=%b gnt=%b want 0 0", rr_mem_we, rr_cpu_gnt);
    end
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    vectors++;
    if (mem_rr[32] !== 32'h0) begin
      miscompares++;
      $display("FAIL abort_nowrite: mem[0x80]=%h want 00000000", mem_rr[32]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      #1;
      vectors++;
      if ({rr_cpu_gnt, rr_dbg_gnt, rr_cpu_rvalid, rr_dbg_rvalid, rr_mem_we} !== 5'b0) begin
        miscompares++;
        $display("FAIL abort_quiet_t%0d: got %b want 00000", t,
                 {rr_cpu_gnt, rr_dbg_gnt, rr_cpu_rvalid, rr_dbg_rvalid, rr_mem_we});
      end
      @(negedge clk);
    end
  endtask

  task automatic cpu_driver(input int n);
    for (int i = 0; i < n; i++) begin
      int gap = int'($urandom_range(0, 2));
      bit done = 1'b0;
      if (gap > 0) begin
        cpu_req = 1'b0;
        repeat (gap) @(negedge clk);
      end
      cpu_req   = 1'b1;
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 32'($urandom_range(0, 15)) << 2;
      cpu_wdata = $urandom;
      for (int c = 0; c < 30 && !done; c++) begin
        #1;
        if (cpu_we ? rr_cpu_gnt : rr_cpu_rvalid) done = 1'b1;
        @(negedge clk);
      end
      vectors++;
      if (!done) begin
        miscompares++;
        $display("FAIL rand_cpu_timeout: txn %0d not completed in 30 cycles", i);
      end
    end
    cpu_req = 1'b0;
  endtask

  task automatic dbg_driver(input int n);
    for (int i = 0; i < n; i++) begin
      int gap = int'($urandom_range(0, 2));
      bit done = 1'b0;
      if (gap > 0) begin
        dbg_req = 1'b0;
        repeat (gap) @(negedge clk);
      end
      dbg_req   = 1'b1;
      dbg_we    = 1'($urandom_range(0, 1));
      dbg_addr  = 32'($urandom_range(0, 15)) << 2;
      dbg_wdata = $urandom;
      for (int c = 0; c < 30 && !done; c++) begin
        #1;
        if (dbg_we ? rr_dbg_gnt : rr_dbg_rvalid) done = 1'b1;
        @(negedge clk);
      end
      vectors++;
      if (!done) begin
        miscompares++;
        $display("FAIL rand_dbg_timeout: txn %0d not completed in 30 cycles", i);
      end
    end
    dbg_req = 1'b0;
  endtask

  // Transaction-level model: one access at a time; grant the cycle after an
  // idle cycle with a request; tie goes to the port not granted last; reads
  // return the model memory as of the grant.
  task automatic rand_monitor();
    logic [31:0] model_mem [64];
    bit          pend_gnt = 1'b0, pend_rv = 1'b0;
    logic        pend_port = 1'b0, pend_we = 1'b0, rv_port = 1'b0, last = 1'b1;
    logic [31:0] pend_addr = '0, pend_wdata = '0, rv_data = '0;
    logic [31:0] m_cpu_rdata = '0, m_dbg_rdata = '0;
    for (int i = 0; i < 64; i++) model_mem[i] = '0;
    while (!rand_done) begin
      bit          nxt_rv;
      logic        nxt_rv_port;
      logic [31:0] nxt_rv_data;
      @(negedge clk); #1;
      vectors++;
      if ({rr_cpu_gnt, rr_dbg_gnt, rr_mem_we} !==
          {pend_gnt && !pend_port, pend_gnt && pend_port, pend_gnt && pend_we}) begin
        miscompares++;
        $display("FAIL rand_gnt @%0t: cpu/dbg/memrw=%b want %b", $time, {rr_cpu_gnt, rr_dbg_gnt, rr_mem_we},
                 {pend_gnt && !pend_port, pend_gnt && pend_port, pend_gnt && pend_we});
      end
      if (pend_gnt) begin
        vectors++;
        if (rr_mem_addr !== pend_addr || (pend_we && rr_mem_wdata !== pend_wdata)) begin
          miscompares++;
          $display("FAIL rand_bus @%0t: addr=%h data=%h want %h %h", $time, rr_mem_addr, rr_mem_wdata,
                   pend_addr, pend_wdata);
        end
        if (pend_we) model_mem[pend_addr[7:2]] = pend_wdata;
      end
      if (pend_rv) begin
        if (rv_port) m_dbg_rdata = rv_data;
        else         m_cpu_rdata = rv_data;
      end
      vectors++;
      if ({rr_cpu_rvalid, rr_dbg_rvalid} !== {pend_rv && !rv_port, pend_rv && rv_port} ||
          rr_cpu_rdata !== m_cpu_rdata || rr_dbg_rdata !== m_dbg_rdata) begin
        miscompares++;
        $display("FAIL rand_resp @%0t: rvalid=%b cpu=%h dbg=%h want %b %h %h", $time,
                 {rr_cpu_rvalid, rr_dbg_rvalid}, rr_cpu_rdata, rr_dbg_rdata,
                 {pend_rv && !rv_port, pend_rv && rv_port}, m_cpu_rdata, m_dbg_rdata);
      end
      vectors++;
      if (rr_cpu_stall !== (cpu_req && !((pend_gnt && !pend_port && pend_we) || (pend_rv && !rv_port)))) begin
        miscompares++;
        $display("FAIL rand_stall @%0t: got %b", $time, rr_cpu_stall);
      end
      nxt_rv      = pend_gnt && !pend_we;
      nxt_rv_port = pend_port;
      nxt_rv_data = model_mem[pend_addr[7:2]];
      if (!pend_gnt && !pend_rv && (cpu_req || dbg_req)) begin
        pend_port  = (cpu_req && dbg_req) ? !last : dbg_req;
        last       = pend_port;
        pend_gnt   = 1'b1;
        pend_we    = pend_port ? dbg_we    : cpu_we;
        pend_addr  = pend_port ? dbg_addr  : cpu_addr;
        pend_wdata = pend_port ? dbg_wdata : cpu_wdata;
      end else begin
        pend_gnt = 1'b0;
      end
      pend_rv = nxt_rv;
      rv_port = nxt_rv_port;
      rv_data = nxt_rv_data;
    end
  endtask

  task automatic test_random();
    do_reset(1'b1);
    rand_done = 1'b0;
    fork
      begin
        fork
          cpu_driver(40);
          dbg_driver(40);
        join
        rand_done = 1'b1;
      end
      rand_monitor();
    join
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_clr = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    repeat (2) @(negedge clk);
    mem_clr = 1'b0;
    test_reset();
    test_store_load();
    test_dbg_loader();
    test_alternate();
    test_fixed_prio();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single-port data memory between the CPU load/store path and a debug/loader port. Requests are serialized through a small state machine with round-robin arbitration. The memory's one-cycle synchronous read latency is absorbed internally. A stall signal freezes the CPU's PC and register write-back until its access completes. The block sits between the CPU datapath (ALU address, store generator, load generator) and `data_memory`.

## Interface
- `ADDR_W`, 32: address width, all ports.
- `DATA_W`, 32: data width, all ports.
- `FIXED_PRIO`, 0: 0 = round-robin; 1 = CPU always wins ties.
- `I_clk`  in  1  rising-edge clock.
- `I_rst`  in  1  reset, asynchronous, active-low.
- `I_cpu_req`  in  1  CPU access request; held with addr/we/wdata stable until completion.
- `I_cpu_we`  in  1  1 = store, 0 = load.
- `I_cpu_addr`  in  ADDR_W  CPU address.
- `I_cpu_wdata`  in  DATA_W  CPU store data.
- `O_cpu_gnt`  out  1  one-cycle pulse: CPU access presented to memory.
- `O_cpu_rvalid`  out  1  one-cycle pulse: `O_cpu_rdata` valid.
- `O_cpu_rdata`  out  DATA_W  load data.
- `O_cpu_stall`  out  1  CPU must hold state this cycle.
- `I_dbg_req`, `I_dbg_we`, `I_dbg_addr`, `I_dbg_wdata`, `O_dbg_gnt`, `O_dbg_rvalid`, `O_dbg_rdata`: same as the CPU port, for the debug/loader port.
- `O_mem_memrw`  out  1  memory write enable.
- `O_mem_address`  out  ADDR_W  memory address.
- `O_mem_data`  out  DATA_W  memory write data.
- `I_mem_data`  in  DATA_W  memory read data, valid the cycle after the address.

## Operation
- States:
  - IDLE: arbitrate.
  - ACCESS: drive memory; `O_x_gnt` = 1.
  - RESP: read data returns; `O_x_rvalid` = 1.
- IDLE, no request: stay in IDLE.
- IDLE, any request: register the winner (`owner`) and its addr/we/wdata, then go to ACCESS.
- ACCESS: memory is driven from the registered values, with `O_mem_memrw` = `we`.
  - Write: go to IDLE.
  - Read: go to RESP.
- RESP: `O_x_rdata` = `I_mem_data`; go to IDLE.
- Arbitration when both ports request:
  - `FIXED_PRIO`=1: the CPU wins.
  - `FIXED_PRIO`=0: the port not recorded in `last` wins.
- `last` is updated on every grant.
- A single requester always wins.
- Completion: a write completes at `gnt`; a read completes at `rvalid`.
- A request still high in the IDLE cycle after completion is treated as a new request.
- `O_cpu_stall` is combinational: `I_cpu_req` & ~(CPU completion this cycle).
- `O_mem_memrw` = 1 only in ACCESS with a registered write. It is never 1 in any other state.
- When not owned or not in RESP, `O_x_rdata` holds its last value. All `gnt`/`rvalid` outputs are 0 outside their states.

## Timing
- Reset (asynchronous assert; deassert synchronized by the environment):
  - State = IDLE, `last` = dbg (the CPU wins the first tie).
  - All `gnt`/`rvalid`/`memrw` = 0.
  - Address, data and `rdata` registers = 0.
- Write latency: req at cycle N → `gnt` and `memrw` at N+1 → IDLE at N+2.
- Read latency: req at N → `gnt` and memory address at N+1 → `rvalid`/`rdata` at N+2.
- Throughput, back-to-back:
  - Writes: 1 per 2 cycles.
  - Reads: 1 per 3 cycles.
- CPU stall duration:
  - Store: `O_cpu_stall` high for cycle N only.
  - Load: high for N and N+1; low at N+2.
- Dropping a request after arbitration does not abort the access; the access completes.
- Reset asserted in ACCESS or RESP aborts immediately. No memory write occurs after reset assertion.

## Structure
- Shared package `arb_pkg`:
  - State encoding IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - Port IDs `PORT_CPU`=1'b0, `PORT_DBG`=1'b1.
- One natural sub-module, `rr_arbiter2`: 2-requester round-robin picker. It takes req[1:0], `last` and `FIXED_PRIO`, and returns the winner.
- The FSM, request capture registers and output muxing live in the top.

## Test plan
- Reset with both requests high → after release, the CPU is granted first; `O_mem_memrw`=0 throughout reset.
- CPU store 0xDEADBEEF to 0x10 at N:
  - `O_cpu_gnt`, `O_mem_memrw`=1 and `O_mem_address`=0x10 at N+1.
  - Stall high only at N.
  - A following CPU load of 0x10 returns 0xDEADBEEF with `rvalid` two cycles after arbitration.
- Both ports hold read requests continuously (`FIXED_PRIO`=0) → grants alternate CPU, dbg, CPU, dbg, with each read taking 3 cycles.
- Same as above with `FIXED_PRIO`=1 → the CPU wins every time; dbg is granted only after the CPU drops its request.
- Debug loader writes 0x1..0x4 to 0x0..0xC while the CPU is idle → 4 grants, 2 cycles apart; `O_cpu_stall` stays 0.
- Reset asserted during ACCESS of a write → `O_mem_memrw` drops asynchronously, the state returns to IDLE, and no `gnt`/`rvalid` is issued afterwards.
